fetch_stage: RTL and testbench

Instruction fetch stage of the 16-bit core, directly upstream of the instruction decoder. Holds the program counter and issues one word-addressed read at a time to instruction memory. Captures the returned word into an instruction register and presents it to the decoder with a valid/stall handshake. Supports branch/jump redirection, including squashing of an in-flight read.

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage_if.sv | 15 +
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants: instruction width, the decoder's NOP word and the
// fetch state encoding.
package fetch_stage_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = 16'b0000000000100000;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory read port: one request at a time, response some cycles later.
interface fetch_stage_if #(
    parameter int ADDR_W = 16
);
    import fetch_stage_pkg::*;

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_rvalid;

    modport master (output mem_req, mem_addr, input mem_rdata, mem_rvalid);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_rvalid);

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding-read FSM and the instruction
// register presented to the decoder.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    fetch_stage_if.master       mem,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   instr_pc
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              drop;

    // Request path depends only on state, pc and redirect; a redirect in REQ
    // suppresses the request so the stale pc never reaches memory.
    always_comb begin
        mem.mem_req  = (state == ST_REQ) && !redirect_valid;
        mem.mem_addr = pc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr       <= NOP;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (redirect_valid) pc <= redirect_addr;
                    else                state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid && drop) begin
                        drop  <= 1'b0;
                        state <= ST_REQ;
                        if (redirect_valid) pc <= redirect_addr;
                    end else if (mem.mem_rvalid && redirect_valid) begin
                        pc    <= redirect_addr;
                        state <= ST_REQ;
                    end else if (mem.mem_rvalid) begin
                        instr       <= mem.mem_rdata;
                        instr_valid <= 1'b1;
                        instr_pc    <= pc;
                        pc          <= pc + 1'b1;
                        state       <= ST_HOLD;
                    end else if (redirect_valid) begin
                        // Read still in flight: remember to discard its data.
                        pc   <= redirect_addr;
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        instr       <= NOP;
                        instr_valid <= 1'b0;
                        pc          <= redirect_addr;
                        state       <= ST_REQ;
                    end else if (!stall) begin
                        instr       <= NOP;
                        instr_valid <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, directed scenarios and
// a randomized run against an outstanding-read reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;

    fetch_stage_if #(.ADDR_W(16)) mif ();

    fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .mem(mif.master), .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc)
    );

    always #5 clock = ~clock;

    int ncmp = 0;
    int nerr = 0;
    int proto_viol = 0;

    // memory model state
    bit          pend;
    int          cnt;
    int          lat;
    logic [15:0] paddr;
    bit          inject_stale;

    // reference model: outstanding read / held instruction
    logic [15:0] m_pc, m_instr, m_ipc;
    bit          m_busy, m_squash, m_have;
    bit          exp_req, last_req;
    logic [15:0] exp_addr, last_addr;

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        if (a == 16'h0001) return 16'h5678;
        return a ^ 16'hC3A5;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = NOP; m_ipc = 16'h0000;
        m_busy = 0; m_squash = 0; m_have = 0;
    endtask

    // One clock: memory drives its response, request is sampled, model advances.
    task automatic step();
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 16'h0000;
        if (inject_stale) begin
            mif.mem_rvalid = 1'b1; mif.mem_rdata = 16'hDEAD; inject_stale = 0;
        end else if (pend && cnt == 0) begin
            mif.mem_rvalid = 1'b1; mif.mem_rdata = memval(paddr); pend = 0;
        end
        #1;
        exp_req   = !m_busy && !m_have && !redirect_valid;
        exp_addr  = m_pc;
        last_req  = mif.mem_req;
        last_addr = mif.mem_addr;
        if (mif.mem_rvalid && m_have) proto_viol++;
        if (last_req) begin
            if (pend) proto_viol++;
            pend = 1; paddr = last_addr; cnt = lat;
        end
        if (m_have) begin
            if (redirect_valid) begin m_have = 0; m_pc = redirect_addr; end
            else if (!stall) m_have = 0;
        end else if (!m_busy) begin
            if (redirect_valid) m_pc = redirect_addr;
            else m_busy = 1;
        end else if (mif.mem_rvalid) begin
            m_busy = 0;
            if (m_squash) begin
                m_squash = 0;
                if (redirect_valid) m_pc = redirect_addr;
            end else if (redirect_valid) begin
                m_pc = redirect_addr;
            end else begin
                m_have = 1; m_instr = mif.mem_rdata; m_ipc = m_pc;
                m_pc = 16'((32'(m_pc) + 1) % 65536);
            end
        end else if (redirect_valid) begin
            m_pc = redirect_addr; m_squash = 1;
        end
        @(posedge clock); #1;
        if (pend && cnt > 0) cnt--;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 16'h0;
        pend = 0; inject_stale = 0; lat = 1;
        mif.mem_rvalid = 1'b0; mif.mem_rdata = 16'h0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 16'h0;
        mif.mem_rvalid = 1'b0; mif.mem_rdata = 16'h0;
        repeat (2) @(posedge clock); #2;
        ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        ncmp++; if (instr !== NOP) begin nerr++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        ncmp++; if (instr_pc !== 16'h0) begin nerr++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
        do_reset();
        ncmp++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 16'h0000) begin
            nerr++; $display("FAIL reset_req: got req=%b addr=%h want req=1 addr=0000", mif.mem_req, mif.mem_addr);
        end
        // async clear while holding an instruction
        stall = 1'b1; step(); step();
        #2 reset = 1'b1; #1;
        ncmp++; if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 16'h0) begin
            nerr++; $display("FAIL async_reset: got v=%b i=%h pc=%h want v=0 i=%h pc=0000", instr_valid, instr, instr_pc, NOP);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            step();
            ncmp++; if (instr_valid !== (c == 2 || c == 5)) begin
                nerr++; $display("FAIL basic_valid c%0d: got %b want %b", c, instr_valid, (c == 2 || c == 5));
            end
            if (c == 2 || c == 5) begin
                ncmp++; if (instr !== (c == 2 ? 16'h1234 : 16'h5678) || instr_pc !== (c == 2 ? 16'h0 : 16'h1)) begin
                    nerr++; $display("FAIL basic_instr c%0d: got %h@%h want %h@%h", c, instr, instr_pc,
                                     (c == 2 ? 16'h1234 : 16'h5678), (c == 2 ? 16'h0 : 16'h1));
                end
            end else begin
                ncmp++; if (instr !== NOP) begin nerr++; $display("FAIL basic_nop c%0d: got %h want %h", c, instr, NOP); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1; step(); step();
        for (int k = 0; k < 4; k++) begin
            step();
            ncmp++; if (last_req !== 1'b0 || instr_valid !== 1'b1 || instr !== 16'h1234) begin
                nerr++; $display("FAIL stall_hold k%0d: got req=%b v=%b i=%h want 0 1 1234", k, last_req, instr_valid, instr);
            end
        end
        stall = 1'b0; step();
        ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL stall_release: got v=%b want 0", instr_valid); end
        step();
        ncmp++; if (last_req !== 1'b1 || last_addr !== 16'h0001) begin
            nerr++; $display("FAIL stall_next_addr: got req=%b addr=%h want 1 0001", last_req, last_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit got_req = 0;
        bit done = 0;
        do_reset();
        lat = 3;
        step();
        redirect_valid = 1'b1; redirect_addr = 16'h0040;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (last_req && !got_req) begin
                got_req = 1;
                ncmp++; if (last_addr !== 16'h0040) begin nerr++; $display("FAIL rw_addr: got %h want 0040", last_addr); end
            end
            if (instr_valid) begin
                done = 1;
                ncmp++; if (instr_pc !== 16'h0040 || instr !== memval(16'h0040)) begin
                    nerr++; $display("FAIL rw_instr: got %h@%h want %h@0040", instr, instr_pc, memval(16'h0040));
                end
            end
        end
        ncmp++; if (!done) begin nerr++; $display("FAIL rw_timeout: got no valid instruction want one within 20 cycles"); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        stall = 1'b1; step(); step();
        redirect_valid = 1'b1; redirect_addr = 16'h0080;
        step();
        redirect_valid = 1'b0;
        ncmp++; if (instr_valid !== 1'b0 || instr !== NOP) begin
            nerr++; $display("FAIL rh_drop: got v=%b i=%h want 0 %h", instr_valid, instr, NOP);
        end
        step();
        ncmp++; if (last_req !== 1'b1 || last_addr !== 16'h0080) begin
            nerr++; $display("FAIL rh_addr: got req=%b addr=%h want 1 0080", last_req, last_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        step();
        ncmp++; if (last_req !== 1'b1 || last_addr !== 16'hFFFF) begin
            nerr++; $display("FAIL wrap_req: got req=%b addr=%h want 1 ffff", last_req, last_addr);
        end
        step();
        ncmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || instr !== memval(16'hFFFF)) begin
            nerr++; $display("FAIL wrap_instr: got v=%b %h@%h want 1 %h@ffff", instr_valid, instr, instr_pc, memval(16'hFFFF));
        end
        step(); step();
        ncmp++; if (last_req !== 1'b1 || last_addr !== 16'h0000) begin
            nerr++; $display("FAIL wrap_next: got req=%b addr=%h want 1 0000", last_req, last_addr);
        end
    endtask

    task automatic test_reset_mid_read();
        bit done = 0;
        do_reset();
        lat = 3;
        step(); step();
        reset = 1'b1; pend = 0;
        @(posedge clock); #1 reset = 1'b0;
        model_reset();
        inject_stale = 1; #1;
        ncmp++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 16'h0000) begin
            nerr++; $display("FAIL rmr_req: got req=%b addr=%h want 1 0000", mif.mem_req, mif.mem_addr);
        end
        step();
        ncmp++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rmr_stale: got v=%b want 0", instr_valid); end
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (instr_valid) begin
                done = 1;
                ncmp++; if (instr !== 16'h1234 || instr_pc !== 16'h0000) begin
                    nerr++; $display("FAIL rmr_instr: got %h@%h want 1234@0000", instr, instr_pc);
                end
            end
        end
        ncmp++; if (!done) begin nerr++; $display("FAIL rmr_timeout: got no valid instruction want one within 20 cycles"); end
    endtask

    task automatic test_random();
        int nvalid = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            stall          = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 99) < 12);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
            lat            = $urandom_range(1, 4);
            step();
            ncmp++; if (last_req !== exp_req) begin nerr++; $display("FAIL rnd_req i%0d: got %b want %b", i, last_req, exp_req); end
            if (exp_req) begin
                ncmp++; if (last_addr !== exp_addr) begin nerr++; $display("FAIL rnd_addr i%0d: got %h want %h", i, last_addr, exp_addr); end
            end
            ncmp++; if (instr_valid !== m_have) begin nerr++; $display("FAIL rnd_valid i%0d: got %b want %b", i, instr_valid, m_have); end
            ncmp++; if (instr !== (m_have ? m_instr : NOP)) begin
                nerr++; $display("FAIL rnd_instr i%0d: got %h want %h", i, instr, (m_have ? m_instr : NOP));
            end
            if (m_have) begin
                nvalid++;
                ncmp++; if (instr_pc !== m_ipc || instr !== memval(m_ipc)) begin
                    nerr++; $display("FAIL rnd_pc i%0d: got %h@%h want %h@%h", i, instr, instr_pc, memval(m_ipc), m_ipc);
                end
            end
        end
        ncmp++; if (proto_viol != 0) begin nerr++; $display("FAIL protocol: got %0d violations want 0", proto_viol); end
        ncmp++; if (nvalid == 0) begin nerr++; $display("FAIL rnd_activity: got 0 valid cycles want >0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
